// File: rtl/dt_engine.sv
// Chessboard distance-transform engine: loads a packed binary image from ROM into
// the result RAM, then optionally runs a forward and a backward min-plus-one sweep.
module dt_engine #(
  parameter  int IMG_W  = 128,
  parameter  int IMG_H  = 128,
  parameter  int WORD_W = 16,
  parameter  int PIX_W  = 8,
  localparam int SA_W   = $clog2(IMG_W*IMG_H/WORD_W),
  localparam int RA_W   = $clog2(IMG_W*IMG_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic              sti_rd,
  output logic [SA_W-1:0]   sti_addr,
  input  logic [WORD_W-1:0] sti_di,
  output logic              res_rd,
  output logic              res_wr,
  output logic [RA_W-1:0]   res_addr,
  output logic [PIX_W-1:0]  res_do,
  input  logic [PIX_W-1:0]  res_di
);
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = RA_W - CW;
  localparam int NWORDS = IMG_W*IMG_H/WORD_W;
  localparam int BW     = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [2:0] {IDLE, LOAD_RD, LOAD_WR, FWD, BWD, DONE} state_t;
  state_t state;

  logic              mode_q, rd_wait, bwd, ld_bit, pix_done;
  logic              adv_swap, adv_fin;
  logic [BW-1:0]     bit_cnt;
  logic [WORD_W-1:0] shreg;
  logic [RW-1:0]     row, adv_row;
  logic [CW-1:0]     col, adv_col;
  logic [2:0]        nb;
  logic [PIX_W-1:0]  cen_q, acc, do_q, mn, inc, wval;
  logic [RA_W-1:0]   cen_addr, off, nbr_addr;

  assign bwd      = (state == BWD);
  assign cen_addr = {row, col};
  assign nbr_addr = cen_addr + off;

  // The first bit of a word goes straight from the ROM bus so each word costs WORD_W+1 cycles.
  assign ld_bit = (bit_cnt == '0) ? sti_di[WORD_W-1] : shreg[WORD_W-1];
  assign res_do = (state == LOAD_WR) ? PIX_W'(ld_bit) : do_q;

  assign mn       = (res_di < acc) ? res_di : acc;
  assign inc      = (mn == '1) ? mn : mn + 1'b1;
  assign wval     = (bwd && cen_q < inc) ? cen_q : inc;
  assign pix_done = res_wr | (rd_wait & (nb == 3'd0) & (res_di == '0));

  // Offset of the neighbour read after the one being consumed (nb = reads done so far).
  always_comb begin
    case (nb)
      3'd0:    off = bwd ? RA_W'(1)         : RA_W'(-IMG_W-1);
      3'd1:    off = bwd ? RA_W'(IMG_W-1)   : RA_W'(-IMG_W);
      3'd2:    off = bwd ? RA_W'(IMG_W)     : RA_W'(-IMG_W+1);
      default: off = bwd ? RA_W'(IMG_W+1)   : RA_W'(-1);
    endcase
  end

  always_comb begin
    adv_row  = row;
    adv_col  = col;
    adv_swap = 1'b0;
    adv_fin  = 1'b0;
    if (!bwd) begin
      if (col != CW'(IMG_W-2)) adv_col = col + 1'b1;
      else if (row != RW'(IMG_H-2)) begin adv_row = row + 1'b1; adv_col = CW'(1); end
      else begin adv_row = RW'(IMG_H-2); adv_col = CW'(IMG_W-2); adv_swap = 1'b1; end
    end else begin
      if (col != CW'(1)) adv_col = col - 1'b1;
      else if (row != RW'(1)) begin adv_row = row - 1'b1; adv_col = CW'(IMG_W-2); end
      else adv_fin = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;  mode_q <= 1'b0; busy <= 1'b0; done <= 1'b0;
      sti_rd <= 1'b0; sti_addr <= '0; res_rd <= 1'b0; res_wr <= 1'b0; res_addr <= '0;
      do_q <= '0; bit_cnt <= '0; shreg <= '0; row <= '0; col <= '0; nb <= '0;
      rd_wait <= 1'b0; cen_q <= '0; acc <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state <= LOAD_RD; mode_q <= mode; busy <= 1'b1; done <= 1'b0;
          sti_rd <= 1'b1; sti_addr <= '0; res_addr <= '0;
        end
        LOAD_RD: begin
          sti_rd <= 1'b0; res_wr <= 1'b1; bit_cnt <= '0; state <= LOAD_WR;
        end
        LOAD_WR: begin
          res_addr <= res_addr + 1'b1;
          bit_cnt  <= bit_cnt + 1'b1;
          shreg    <= ((bit_cnt == '0) ? sti_di : shreg) << 1;
          if (bit_cnt == BW'(WORD_W-1)) begin
            res_wr <= 1'b0;
            if (sti_addr != SA_W'(NWORDS-1)) begin
              sti_addr <= sti_addr + 1'b1; sti_rd <= 1'b1; state <= LOAD_RD;
            end else if (mode_q) begin
              state <= FWD; row <= RW'(1); col <= CW'(1); nb <= '0;
              res_rd <= 1'b1; res_addr <= {RW'(1), CW'(1)};
            end else begin
              state <= DONE; done <= 1'b1; busy <= 1'b0;
            end
          end
        end
        FWD, BWD: begin
          if (res_rd) begin
            res_rd <= 1'b0; rd_wait <= 1'b1;
          end else if (pix_done) begin
            rd_wait <= 1'b0; res_wr <= 1'b0; nb <= '0;
            if (adv_fin) begin
              state <= DONE; done <= 1'b1; busy <= 1'b0;
            end else begin
              row <= adv_row; col <= adv_col;
              res_rd <= 1'b1; res_addr <= {adv_row, adv_col};
              if (adv_swap) state <= BWD;
            end
          end else if (rd_wait) begin
            rd_wait <= 1'b0;
            acc <= (nb == 3'd0) ? '1 : mn;
            if (nb == 3'd0) cen_q <= res_di;
            if (nb == 3'd4) begin
              res_wr <= 1'b1; res_addr <= cen_addr; do_q <= wval; nb <= '0;
            end else begin
              nb <= nb + 1'b1; res_rd <= 1'b1; res_addr <= nbr_addr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dt_engine.sv
// Randomized bench for dt_engine on a 16x16 image with 2-bit results, checked
// against an array-based model of the load and the two distance sweeps.
module tb_dt_engine;
  localparam int W = 16, H = 16, WW = 16, PW = 2;
  localparam int NW = W*H/WW, SA = $clog2(NW), RA = $clog2(W*H);
  localparam int MAXV = (1 << PW) - 1;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0;
  logic          busy, done, sti_rd, res_rd, res_wr;
  logic [SA-1:0] sti_addr;
  logic [RA-1:0] res_addr;
  logic [WW-1:0] sti_di;
  logic [PW-1:0] res_do, res_di;

  logic [WW-1:0] rom [NW];
  logic [PW-1:0] ram [W*H];
  int            exp_ram [W*H];
  logic          scramble = 1'b0, scan_ph = 1'b0;
  int            v_rdwr = 0, v_border = 0, v_bd = 0, v_strobe = 0;
  int            n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  dt_engine #(.IMG_W(W), .IMG_H(H), .WORD_W(WW), .PIX_W(PW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .busy(busy), .done(done),
    .sti_rd(sti_rd), .sti_addr(sti_addr), .sti_di(sti_di),
    .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr), .res_do(res_do), .res_di(res_di)
  );

  // ROM and RAM with one-cycle read latency
  always @(posedge clk) begin
    if (sti_rd) sti_di <= rom[sti_addr];
    if (res_rd) res_di <= ram[res_addr];
    if (scramble) for (int a = 0; a < W*H; a++) ram[a] <= PW'($urandom);
    else if (res_wr) ram[res_addr] <= res_do;
  end

  function automatic bit is_border(input int a);
    return (a / W == 0) || (a / W == H-1) || (a % W == 0) || (a % W == W-1);
  endfunction

  // Protocol monitor; scan_ph marks the sweep part of a job (the only place reads occur).
  always @(posedge clk) begin
    if (reset || (start && !busy)) scan_ph <= 1'b0;
    else if (res_rd) scan_ph <= 1'b1;
    if (res_rd && res_wr) v_rdwr++;
    if (res_wr && scan_ph && is_border(int'(res_addr))) v_border++;
    if (busy && done) v_bd++;
    if (done && (res_rd || res_wr || sti_rd)) v_strobe++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  function automatic int mn2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int sat(input int x);
    return (x > MAXV) ? MAXV : x;
  endfunction

  function automatic void model(input bit m);
    int v [H][W];
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        v[r][c] = int'(rom[(r*W+c)/WW][WW-1-((r*W+c)%WW)]);
    if (m) begin
      for (int r = 1; r < H-1; r++)
        for (int c = 1; c < W-1; c++)
          if (v[r][c] != 0)
            v[r][c] = sat(mn2(mn2(v[r-1][c-1], v[r-1][c]), mn2(v[r-1][c+1], v[r][c-1])) + 1);
      for (int r = H-2; r >= 1; r--)
        for (int c = W-2; c >= 1; c--)
          if (v[r][c] != 0)
            v[r][c] = mn2(v[r][c],
                          sat(mn2(mn2(v[r][c+1], v[r+1][c-1]), mn2(v[r+1][c], v[r+1][c+1])) + 1));
    end
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        exp_ram[r*W+c] = v[r][c];
  endfunction

  task automatic clr_img();
    for (int w = 0; w < NW; w++) rom[w] = '0;
  endtask

  task automatic set_px(input int r, input int c);
    int a;
    a = r*W + c;
    rom[a/WW][WW-1-(a%WW)] = 1'b1;
  endtask

  task automatic chk_img(input string tag, input bit m);
    model(m);
    for (int a = 0; a < W*H; a++) chk($sformatf("%s[%0d]", tag, a), 32'(ram[a]), exp_ram[a]);
  endtask

  // Runs one job; lat = clock edges from the start-sampling edge until done is seen.
  task automatic run_job(input bit m, input bit poke, output int lat);
    int poke_at;
    poke_at = poke ? int'($urandom_range(m ? 600 : 260, 5)) : -1;
    @(negedge clk); scramble = 1'b1;
    @(negedge clk); scramble = 1'b0; start = 1'b1; mode = m;
    @(negedge clk); start = 1'b0; mode = 1'($urandom); lat = 0;
    while (!done && lat < 20000) begin
      if (lat == poke_at) begin start = 1'b1; mode = ~m; end
      @(negedge clk);
      if (start) begin start = 1'b0; chk("busy_poke", {busy, done}, 2'b10); end
      lat++;
    end
    chk("job_done", done, 1);
    chk("busy_at_done", busy, 0);
    repeat ($urandom_range(4, 1)) @(negedge clk);
    chk("done_hold", {done, busy, sti_rd, res_rd, res_wr}, 5'b10000);
  endtask

  task automatic set_block();
    clr_img();
    for (int r = 8; r <= 12; r++)
      for (int c = 8; c <= 12; c++) set_px(r, c);
  endtask

  initial begin
    int lat, n, dens;
    bit m;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_outs", {busy, done, sti_rd, res_rd, res_wr, sti_addr, res_addr, res_do}, 0);
    repeat (4) @(negedge clk);
    chk("idle_quiet", {busy, done, sti_rd, res_rd, res_wr}, 0);

    // load only, two set pixels at the ends of word 0
    clr_img(); rom[0] = 16'h8001;
    run_job(1'b0, 1'b1, lat);
    chk("ld_lat", (lat >= NW*(WW+1)-2 && lat <= NW*(WW+1)+2) ? NW*(WW+1) : lat, NW*(WW+1));
    chk("ld_res0", 32'(ram[0]), 1);
    chk("ld_res15", 32'(ram[15]), 1);
    chk("ld_res7", 32'(ram[7]), 0);
    chk_img("ld", 1'b0);

    // full transform of a 5x5 block
    set_block();
    run_job(1'b1, 1'b1, lat);
    chk("blk_10_10", 32'(ram[10*W+10]), 3);
    chk("blk_9_10", 32'(ram[9*W+10]), 2);
    chk("blk_8_8", 32'(ram[8*W+8]), 1);
    chk_img("blk", 1'b1);

    // saturation: everything but the border set
    clr_img();
    for (int r = 1; r < H-1; r++)
      for (int c = 1; c < W-1; c++) set_px(r, c);
    run_job(1'b1, 1'b0, lat);
    chk("sat_centre", 32'(ram[8*W+8]), 3);
    chk("sat_2_2", 32'(ram[2*W+2]), 2);
    chk("sat_1_1", 32'(ram[1*W+1]), 1);
    chk_img("sat", 1'b1);

    // reset in the middle of the forward sweep, then a clean rerun
    set_block();
    @(negedge clk); start = 1'b1; mode = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!res_rd && n < 2000) begin @(negedge clk); n++; end
    chk("midrst_fwd_seen", res_rd, 1);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("midrst_outs", {busy, done, sti_rd, res_rd, res_wr, sti_addr, res_addr, res_do}, 0);
    repeat (3) @(negedge clk);
    chk("midrst_quiet", {busy, done, sti_rd, res_rd, res_wr}, 0);
    run_job(1'b1, 1'b0, lat);
    chk("rerun_10_10", 32'(ram[10*W+10]), 3);
    chk_img("rerun", 1'b1);

    // random images, random mode
    repeat (3) begin
      clr_img();
      dens = int'($urandom_range(90, 20));
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          if (int'($urandom_range(99, 0)) < dens) set_px(r, c);
      m = 1'($urandom);
      run_job(m, 1'b1, lat);
      chk_img(m ? "rnd_dt" : "rnd_ld", m);
    end

    chk("rd_wr_excl", v_rdwr, 0);
    chk("border_wr", v_border, 0);
    chk("busy_done", v_bd, 0);
    chk("done_strobes", v_strobe, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
